// File: rtl/uart_core_param_if.sv
// Host/line side of uart_core_param: TX handshake, serial pins and RX result.
// The core binds to slave; the host or bench binds to master.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 i_tx_valid;
  logic                 o_tx_ready;
  logic                 o_tx;
  logic                 o_tx_active;
  logic                 o_tx_done;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;

  modport master (
    output i_tx_data, i_tx_valid, i_rx,
    input  o_tx_ready, o_tx, o_tx_active, o_tx_done,
    input  o_rx_data, o_rx_valid, o_parity_err, o_frame_err
  );

  modport slave (
    input  i_tx_data, i_tx_valid, i_rx,
    output o_tx_ready, o_tx, o_tx_active, o_tx_done,
    output o_rx_data, o_rx_valid, o_parity_err, o_frame_err
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: independent TX and RX engines with configurable
// data width, parity and stop bits, ready/valid TX handshake and RX error flags.
module uart_core_param #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic               clock,
  input  logic               reset,
  uart_core_param_if.slave   bus
);

  localparam int CW = $clog2(STOP_BITS * CLK_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLK_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SBIT_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);
  localparam bit            HAS_PAR   = (PARITY != 0);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
    end
  end

  // Line and status outputs decode straight from the state register so the
  // start bit appears in the first cycle after accept and reset forces idle at once.
  always_comb begin
    tx_state_n      = tx_state;
    tx_cnt_n        = tx_cnt + 1'b1;
    tx_idx_n        = tx_idx;
    tx_shift_n      = tx_shift;
    tx_par_n        = tx_par;
    bus.o_tx        = 1'b1;
    bus.o_tx_ready  = 1'b0;
    bus.o_tx_active = 1'b1;
    bus.o_tx_done   = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        bus.o_tx_ready  = 1'b1;
        bus.o_tx_active = 1'b0;
        tx_cnt_n        = '0;
        if (bus.i_tx_valid) begin
          tx_shift_n = bus.i_tx_data;
          tx_par_n   = (^bus.i_tx_data) ^ ODD;
          tx_idx_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        bus.o_tx = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        bus.o_tx = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          if (tx_idx == DATA_LAST) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
          else                     tx_idx_n   = tx_idx + 1'b1;
        end
      end
      TX_PARITY: begin
        bus.o_tx = tx_par;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == STOP_LAST) begin
          bus.o_tx_done = 1'b1;
          tx_cnt_n      = '0;
          tx_state_n    = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic                 rx_meta, rx_sync;
  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [IW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_perr, rx_perr_n;
  logic                 rx_ferr, rx_ferr_n;
  logic                 rx_hold, rx_hold_n;
  logic                 rx_load;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, perr_q, ferr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_hold    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_perr    <= rx_perr_n;
      rx_ferr    <= rx_ferr_n;
      rx_hold    <= rx_hold_n;
      rx_valid_q <= rx_load;
      if (rx_load) begin
        rx_data_q <= rx_shift;
        perr_q    <= rx_perr;
        ferr_q    <= rx_ferr_n;
      end
    end
  end

  // rx_hold keeps a held-low line (break) from re-triggering until it goes high.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_perr_n  = rx_perr;
    rx_ferr_n  = rx_ferr;
    rx_hold_n  = rx_hold & ~rx_sync;
    rx_load    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync && !rx_hold) begin
          rx_perr_n  = 1'b0;
          rx_ferr_n  = 1'b0;
          rx_idx_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == DATA_LAST) begin
            rx_idx_n   = '0;
            rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_perr_n  = rx_sync ^ (^rx_shift) ^ ODD;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n  = '0;
          rx_ferr_n = rx_ferr | ~rx_sync;
          if (rx_idx == SBIT_LAST) begin
            rx_load    = 1'b1;
            rx_hold_n  = ~rx_sync;
            rx_state_n = RX_IDLE;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign bus.o_rx_data    = rx_data_q;
  assign bus.o_rx_valid   = rx_valid_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = ferr_q;

endmodule
